// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types, opcodes and decoded-instruction bundle for the decode stage
package decode_stage_pkg;
  typedef logic [31:0] word;
  typedef logic [4:0] reg_index;
  typedef enum logic {READ_REG_DATA, WRITE_REG_DATA} reg_file_op_t;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;
  typedef struct packed {
    word        pc;
    word        rs1_val;
    word        rs2_val;
    word        imm;
    reg_index   rd;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       writes_rd;
    logic       illegal;
  } decoded_instr_t;
endpackage

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: sign-extended RV32I immediate from instruction word and format
import decode_stage_pkg::*;
module decode_stage_imm_gen (
  input  word       instr,
  input  imm_type_t imm_type,
  output word       imm
);
  // pick the bit scatter of the selected format, sign taken from instr[31]
  always_comb begin
    imm = imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
          imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          imm_type == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_U ? {instr[31:12], 12'b0} :
          imm_type == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          '0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with reg_file port arbitration and busy scoreboard
import decode_stage_pkg::*;
module decode_stage #(
  parameter word RESET_PC_OUT = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  word          in_instr,
  input  word          in_pc,
  input  logic         flush,
  input  logic         wb_valid,
  input  reg_index     wb_rd,
  input  word          wb_data,
  output reg_file_op_t rf_op,
  output reg_index     rf_rs1,
  output reg_index     rf_rs2,
  output reg_index     rf_rd,
  output word          rf_write_data,
  input  word          rf_rs1_data,
  input  word          rf_rs2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output word          out_pc,
  output word          out_rs1_val,
  output word          out_rs2_val,
  output word          out_imm,
  output reg_index     out_rd,
  output logic [6:0]   out_opcode,
  output logic [2:0]   out_funct3,
  output logic         out_funct7_b5,
  output logic         out_writes_rd,
  output logic         out_illegal
);
  localparam decoded_instr_t RST_OUT = '{pc: RESET_PC_OUT, default: '0};
  logic [6:0] opc;
  reg_index rs1, rs2, rd;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_op_imm, is_op;
  logic uses_rs1, uses_rs2, writes_rd, legal, hazard, accept;
  imm_type_t imm_type;
  word imm;
  decoded_instr_t dec, out_d, out_q;
  logic valid_d, valid_q;
  logic [31:0] busy_d, busy_q;
  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign is_lui    = opc == OPC_LUI;
  assign is_auipc  = opc == OPC_AUIPC;
  assign is_jal    = opc == OPC_JAL;
  assign is_jalr   = opc == OPC_JALR;
  assign is_branch = opc == OPC_BRANCH;
  assign is_load   = opc == OPC_LOAD;
  assign is_store  = opc == OPC_STORE;
  assign is_op_imm = opc == OPC_OP_IMM;
  assign is_op     = opc == OPC_OP;
  assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_op_imm | is_op;
  assign uses_rs1  = is_jalr | is_branch | is_load | is_store | is_op_imm | is_op;
  assign uses_rs2  = is_branch | is_store | is_op;
  assign writes_rd = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_op_imm | is_op) & (rd != '0);
  assign imm_type  = (is_jalr | is_load | is_op_imm) ? IMM_I :
                     is_store ? IMM_S :
                     is_branch ? IMM_B :
                     (is_lui | is_auipc) ? IMM_U :
                     is_jal ? IMM_J : IMM_NONE;
  // only the registered scoreboard gates issue; a writeback frees its register one cycle later
  assign hazard   = (uses_rs1 & busy_q[rs1]) | (uses_rs2 & busy_q[rs2]) | (writes_rd & busy_q[rd]);
  assign in_ready = (!valid_q | out_ready) & !hazard & !wb_valid & !flush;
  assign accept   = in_valid & in_ready;
  decode_stage_imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );
  assign dec = '{
    pc:        in_pc,
    rs1_val:   uses_rs1 ? rf_rs1_data : '0,
    rs2_val:   uses_rs2 ? rf_rs2_data : '0,
    imm:       imm,
    rd:        rd,
    opcode:    opc,
    funct3:    in_instr[14:12],
    funct7_b5: in_instr[30],
    writes_rd: writes_rd,
    illegal:   !legal
  };
  // writeback owns the single reg_file port whenever it is present
  always_comb begin
    rf_op         = wb_valid ? WRITE_REG_DATA : READ_REG_DATA;
    rf_rd         = wb_valid ? wb_rd : '0;
    rf_write_data = wb_valid ? wb_data : '0;
    rf_rs1        = wb_valid ? '0 : rs1;
    rf_rs2        = wb_valid ? '0 : rs2;
  end
  // output register and scoreboard next state; a set on accept wins over any clear
  always_comb begin
    out_d   = accept ? dec : out_q;
    valid_d = accept | (valid_q & !out_ready & !flush);
    busy_d  = busy_q;
    if (flush && valid_q && out_q.writes_rd) busy_d[out_q.rd] = 1'b0;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && writes_rd) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      busy_q  <= '0;
      out_q   <= RST_OUT;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end
  assign out_valid     = valid_q;
  assign out_pc        = out_q.pc;
  assign out_rs1_val   = out_q.rs1_val;
  assign out_rs2_val   = out_q.rs2_val;
  assign out_imm       = out_q.imm;
  assign out_rd        = out_q.rd;
  assign out_opcode    = out_q.opcode;
  assign out_funct3    = out_q.funct3;
  assign out_funct7_b5 = out_q.funct7_b5;
  assign out_writes_rd = out_q.writes_rd;
  assign out_illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, hazards, port arbitration, backpressure and flush
`timescale 1ns/1ps
import decode_stage_pkg::*;
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset_n, in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
  word in_instr, in_pc, wb_data, rf_write_data, rf_rs1_data, rf_rs2_data;
  word out_pc, out_rs1_val, out_rs2_val, out_imm;
  reg_index wb_rd, rf_rs1, rf_rs2, rf_rd, out_rd;
  reg_file_op_t rf_op;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic out_funct7_b5, out_writes_rd, out_illegal;
  word rf [32] = '{default: '0};
  int tests = 0;
  int failed = 0;
  always #5 clock = ~clock;
  decode_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .rf_op(rf_op), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7_b5(out_funct7_b5), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );
  // simple register file model serving the DUT's single port
  assign rf_rs1_data = rf[rf_rs1];
  assign rf_rs2_data = rf[rf_rs2];
  always @(posedge clock) if (rf_op == WRITE_REG_DATA && rf_rd != 0) rf[rf_rd] <= rf_write_data;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  initial begin
    reset_n = 0; in_valid = 1; in_instr = 32'h00700293; in_pc = 32'h100;
    flush = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 0);
    reset_n = 1; in_valid = 0; #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1; in_instr = 32'h00700293; in_pc = 32'h100; #1;
    chk("addi_in_ready", 32'(in_ready), 1);
    tick();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_imm", out_imm, 32'd7);
    chk("addi_rd", 32'(out_rd), 5);
    chk("addi_wrd", 32'(out_writes_rd), 1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_rs2_unused", out_rs2_val, 32'h0);
    in_instr = 32'h00528333; in_pc = 32'h104; #1;
    chk("raw_stall", 32'(in_ready), 0);
    tick();
    chk("raw_drained", 32'(out_valid), 0);
    chk("raw_still_stall", 32'(in_ready), 0);
    wb_valid = 1; wb_rd = 5; wb_data = 7; #1;
    chk("wb_rf_op", 32'(rf_op), 32'(WRITE_REG_DATA));
    chk("wb_rf_rd", 32'(rf_rd), 5);
    chk("wb_in_ready", 32'(in_ready), 0);
    tick();
    wb_valid = 0; #1;
    chk("raw_release", 32'(in_ready), 1);
    chk("raw_rf_op", 32'(rf_op), 32'(READ_REG_DATA));
    chk("raw_rf_rs1", 32'(rf_rs1), 5);
    tick();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_rs1", out_rs1_val, 32'd7);
    chk("add_rs2", out_rs2_val, 32'd7);
    chk("add_rd", 32'(out_rd), 6);
    chk("add_imm", out_imm, 32'h0);
    chk("add_pc", out_pc, 32'h104);
    in_valid = 0; wb_valid = 1; wb_rd = 6; wb_data = 14;
    tick();
    in_valid = 1; in_instr = 32'h00300393; in_pc = 32'h108; wb_rd = 1; wb_data = 32'h55; #1;
    chk("conf_rf_op", 32'(rf_op), 32'(WRITE_REG_DATA));
    chk("conf_in_ready", 32'(in_ready), 0);
    tick();
    wb_valid = 0; #1;
    chk("conf_no_accept", 32'(out_valid), 0);
    chk("conf_rf_op_rd", 32'(rf_op), 32'(READ_REG_DATA));
    chk("conf_in_ready2", 32'(in_ready), 1);
    tick();
    chk("conf_valid", 32'(out_valid), 1);
    chk("conf_rd", 32'(out_rd), 7);
    chk("conf_imm", out_imm, 32'd3);
    out_ready = 0; in_instr = 32'h00108413; in_pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_rd", 32'(out_rd), 7);
      chk("bp_pc", out_pc, 32'h108);
      chk("bp_imm", out_imm, 32'd3);
    end
    out_ready = 1; #1;
    chk("bp_release", 32'(in_ready), 1);
    tick();
    chk("addi8_rd", 32'(out_rd), 8);
    chk("addi8_rs1", out_rs1_val, 32'h55);
    chk("addi8_imm", out_imm, 32'd1);
    in_valid = 0; out_ready = 0; flush = 1; #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 0;
    chk("flush_valid", 32'(out_valid), 0);
    in_valid = 1; out_ready = 1; in_instr = 32'h008404B3; in_pc = 32'h110; #1;
    chk("flush_no_stall", 32'(in_ready), 1);
    tick();
    chk("add9_valid", 32'(out_valid), 1);
    chk("add9_rd", 32'(out_rd), 9);
    in_instr = 32'h00038533; #1;
    chk("older_busy_kept", 32'(in_ready), 0);
    in_valid = 0;
    tick();
    in_valid = 1; in_instr = 32'hFE000EE3; in_pc = 32'h200;
    tick();
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_wrd", 32'(out_writes_rd), 0);
    chk("beq_opc", 32'(out_opcode), 32'h63);
    chk("beq_illegal", 32'(out_illegal), 0);
    in_instr = 32'hFFFFFFFF; in_pc = 32'h204;
    tick();
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_wrd", 32'(out_writes_rd), 0);
    chk("ill_imm", out_imm, 32'h0);
    chk("ill_rs1", out_rs1_val, 32'h0);
    in_instr = 32'h000F8F93; #1;
    chk("ill_no_busy", 32'(in_ready), 1);
    in_valid = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
